squish_arbiter: RTL and testbench

Shares a single `squish` activation unit among `NUM_REQ` neuron requesters in the XOR network datapath. Arbitrates round-robin, registers the winning 33-bit sign-magnitude pre-activation, evaluates it through `squish`, and returns the 17-bit result tagged with the requester ID over a valid/ready handshake. Sits between the neuron accumulators and the weight-update/output logic. Also keeps a saturating count of compressed, over-range evaluations.

---
 rtl/squish_pkg.sv | 28 ++
 rtl/squish.sv | 24 ++
 rtl/squish_arbiter.sv | 136 +++++++++++++
 tb/tb_squish_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/squish_pkg.sv
// Shared definitions for the squish activation path.
//   SQ_IN_W    width of a sign-magnitude pre-activation (sign + 32-bit magnitude)
//   SQ_OUT_W   width of a squished result (sign + 16-bit magnitude)
//   SQ_THRESH  popcount above which the magnitude is compressed instead of truncated
//   sq_arb_state_t  states of the arbiter that shares one squish unit
package squish_pkg;

    localparam int SQ_IN_W   = 33;
    localparam int SQ_OUT_W  = 17;
    localparam int SQ_THRESH = 16;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } sq_arb_state_t;

    // Number of set bits in the 32-bit magnitude; the sign bit never counts.
    function automatic logic [5:0] sq_popcount(input logic [31:0] mag);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(mag[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/squish.sv
// Combinational squish activation.
//   value   in  33  bit 32 sign, [31:0] magnitude
//   result  out 17  bit 16 sign, [15:0] squished magnitude
// Sparse magnitudes (popcount <= SQ_THRESH) pass their low half straight
// through; dense ones fold each adjacent bit pair with OR so the upper half
// still influences the result.
module squish
    import squish_pkg::*;
(
    input  logic [SQ_IN_W-1:0]  value,
    output logic [SQ_OUT_W-1:0] result
);

    // Default to pass-through, overwrite the magnitude when compressing.
    always_comb begin
        result = {value[SQ_IN_W-1], value[15:0]};
        if (sq_popcount(value[31:0]) > 6'(SQ_THRESH)) begin
            for (int k = 0; k < 16; k++) begin
                result[k] = value[2*k+1] | value[2*k];
            end
        end
    end

endmodule

// File: rtl/squish_arbiter.sv
// Round-robin arbiter sharing one squish unit among NUM_REQ neuron requesters.
//   clk, rst    clock and asynchronous active-high reset
//   req_valid   per-requester request strobe
//   req_data    requester i at [33*i+32:33*i], sign-magnitude
//   req_ready   one-hot grant, only ever raised in IDLE
//   rsp_valid   result held for the consumer
//   rsp_ready   consumer accepts the result
//   rsp_data    squished result, rsp_id names its requester
//   busy        transaction in flight (not IDLE)
//   sat_count   saturating count of evaluations that used the compression path
// One transaction takes three cycles: grant in IDLE, evaluate in EVAL,
// hand off in RESP.
module squish_arbiter
    import squish_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*SQ_IN_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [SQ_OUT_W-1:0]         rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy,
    output logic [15:0]                 sat_count
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    sq_arb_state_t        state;
    sq_arb_state_t        next_state;
    logic [ID_W-1:0]      ptr;
    logic [SQ_IN_W-1:0]   in_reg;
    logic [ID_W-1:0]      id_reg;
    logic [15:0]          sat_cnt;
    logic [SQ_OUT_W-1:0]  squish_out;
    logic                 compress;
    logic [ID_W:0]        pick;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;

    // Returns {found, index} of the first valid requester at or after start,
    // wrapping modulo NUM_REQ. Scanning in reverse lets the closest one win
    // without an early exit.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    start);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (valid[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    squish u_squish (
        .value  (in_reg),
        .result (squish_out)
    );

    assign compress  = sq_popcount(in_reg[31:0]) > 6'(SQ_THRESH);
    assign pick      = rr_pick(req_valid, ptr);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign sat_count = sat_cnt;

    // Next-state and grant decode; a grant only exists while idle.
    always_comb begin
        next_state  = state;
        req_ready   = '0;
        grant_found = 1'b0;
        grant_idx   = pick[ID_W-1:0];
        case (state)
            IDLE: begin
                if (pick[ID_W]) begin
                    grant_found          = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    next_state           = EVAL;
                end
            end
            EVAL: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers: capture on grant, register the squish result in
    // EVAL, and move the round-robin pointer past the served requester once
    // the consumer takes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            in_reg   <= '0;
            id_reg   <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            sat_cnt  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        in_reg <= req_data[SQ_IN_W*grant_idx +: SQ_IN_W];
                        id_reg <= grant_idx;
                    end
                end
                EVAL: begin
                    rsp_data <= squish_out;
                    rsp_id   <= id_reg;
                    if (compress && (sat_cnt != 16'hFFFF)) begin
                        sat_cnt <= sat_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr <= (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_squish_arbiter.sv
// Directed self-checking bench for squish_arbiter with four requesters.
// Inputs are driven just after the falling edge and outputs are sampled
// 1 time unit later, well away from the rising edge.
module tb_squish_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [131:0] req_data;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [16:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;
    logic [15:0]  sat_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [16:0] rr_rsp [4] = '{17'h0_0011, 17'h1_0022, 17'h0_0033, 17'h1_0044};

    squish_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives the request strobes and, when slot >= 0, that requester's data.
    task automatic applyStimulus(input logic [3:0] valid, input int slot,
                                 input logic [32:0] data);
        req_valid = valid;
        if (slot >= 0) begin
            req_data[33*slot +: 33] = data;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // One complete transaction from a single requester, with a cycle of
    // backpressure-free handoff at the end.
    task automatic txn(input string tag, input int id, input logic [32:0] data,
                       input logic [16:0] exp_rsp, input logic [15:0] exp_sat);
        applyStimulus(4'(1 << id), id, data);
        #1;
        checkOutput({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
        tick();
        applyStimulus(4'b0000, -1, 33'h0);
        #1;
        checkOutput({tag, "_eval_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_eval_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_eval_ready"}, 32'(req_ready), 32'd0);
        tick();
        #1;
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_rsp));
        checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
        checkOutput({tag, "_sat"}, 32'(sat_count), 32'(exp_sat));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checkOutput({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_sat", 32'(sat_count), 32'd0);
        rst = 1'b0;
        tick();

        // Pass-through, then the popcount 16 / 17 boundary
        txn("pass", 2, 33'h1_0000_00FF, 17'h1_00FF, 16'd0);
        txn("pop16", 3, 33'h0_FFFF_0000, 17'h0_0000, 16'd0);
        txn("pop17", 0, 33'h0_FFFF_0001, 17'h0_FF01, 16'd1);

        // Backpressure: requester 1 served while 0, 2, 3 wait
        applyStimulus(4'b0010, 1, 33'h0_0000_1234);
        #1;
        checkOutput("bp_grant", 32'(req_ready), 32'b0010);
        tick();
        applyStimulus(4'b1101, -1, 33'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_data", 32'(rsp_data), 32'h0_1234);
            checkOutput("bp_id", 32'(rsp_id), 32'd1);
            checkOutput("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_ptr_advanced", 32'(req_ready), 32'b0100);
        applyStimulus(4'b0000, -1, 33'h0);
        tick();

        // Reset during EVAL drops the transaction
        applyStimulus(4'b1000, 3, 33'h0_FFFF_FFFF);
        #1;
        checkOutput("rmid_grant", 32'(req_ready), 32'b1000);
        tick();
        applyStimulus(4'b0000, -1, 33'h0);
        rst = 1'b1;
        #1;
        checkOutput("rmid_busy", 32'(busy), 32'd0);
        checkOutput("rmid_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rmid_ready", 32'(req_ready), 32'd0);
        checkOutput("rmid_data", 32'(rsp_data), 32'd0);
        checkOutput("rmid_id", 32'(rsp_id), 32'd0);
        checkOutput("rmid_sat", 32'(sat_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        #1;
        checkOutput("rmid_no_rsp_a", 32'(rsp_valid), 32'd0);
        checkOutput("rmid_idle", 32'(busy), 32'd0);
        tick();
        #1;
        checkOutput("rmid_no_rsp_b", 32'(rsp_valid), 32'd0);
        tick();

        // Round-robin with everyone valid; scan restarts at 0 after reset
        applyStimulus(4'b0000, 0, 33'h0_0000_0011);
        applyStimulus(4'b0000, 1, 33'h1_0000_0022);
        applyStimulus(4'b0000, 2, 33'h0_0000_0033);
        applyStimulus(4'b1111, 3, 33'h1_0000_0044);
        rsp_ready = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            #1;
            if (k % 3 == 0) begin
                checkOutput("rr_grant", 32'(req_ready), 32'(1 << ((k / 3) % 4)));
            end else begin
                checkOutput("rr_no_grant", 32'(req_ready), 32'd0);
            end
            if (k % 3 == 2) begin
                checkOutput("rr_valid", 32'(rsp_valid), 32'd1);
                checkOutput("rr_id", 32'(rsp_id), 32'((k / 3) % 4));
                checkOutput("rr_data", 32'(rsp_data), 32'(rr_rsp[(k / 3) % 4]));
            end
            if (k == 12) begin
                applyStimulus(4'b0000, -1, 33'h0);
            end
            tick();
        end
        rsp_ready = 1'b0;
        #1;
        checkOutput("rr_end_idle", 32'(busy), 32'd0);
        checkOutput("rr_end_sat", 32'(sat_count), 32'd0);
        tick();

        // Saturation: preload the counter one below the ceiling
        force dut.sat_cnt = 16'hFFFE;
        #1;
        release dut.sat_cnt;
        #1;
        checkOutput("sat_preload", 32'(sat_count), 32'hFFFE);
        txn("sat_a", 2, 33'h0_FFFF_FFFF, 17'h0_FFFF, 16'hFFFF);
        txn("sat_b", 1, 33'h1_F0FF_F00F, 17'h1_CFC3, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
